// File: rtl/threediff_env_if.sv
// Bus between the threediff controller and its environment responder.
// The slave modport is the responder's view; the master modport is the controller or harness side.
interface threediff_env_if;
  logic [31:0] cmd_y;
  logic        cond_load;
  logic [11:0] cond_data;
  logic [11:0] x;
  logic        keyinput0;
  logic        key_valid;
  logic        busy;
  logic [7:0]  op_count;
  logic        wdog_flag;

  modport slave (
    input  cmd_y, cond_load, cond_data,
    output x, keyinput0, key_valid, busy, op_count, wdog_flag
  );
  modport master (
    output cmd_y, cond_load, cond_data,
    input  x, keyinput0, key_valid, busy, op_count, wdog_flag
  );
endinterface

// File: rtl/threediff_env_responder.sv
// Plant-side model for the threediff controller: actuator completion (x4), static conditions, unlock key.
// Optional idle watchdog is built when THREEDIFF_ENV_WDOG_EN is defined.
module threediff_env_responder #(
  parameter int          DONE_LAT   = 4,
  parameter int          HOLD_CYC   = 2,
  parameter logic [31:0] START_MASK = 32'h0440_0200,
  parameter logic        KEY_VAL    = 1'b1,
  parameter int          WDOG_CYC   = 1024
) (
  input  logic           clk,
  input  logic           rst,
  threediff_env_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  localparam logic [7:0] LAT_M1  = 8'(DONE_LAT - 1);
  localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYC - 1);

  // Reject out-of-range configurations at elaboration.
  if (DONE_LAT < 1 || DONE_LAT > 255 || HOLD_CYC < 1 || HOLD_CYC > 15 ||
      WDOG_CYC < 1 || WDOG_CYC > 65535) begin : g_bad_cfg
    $error("threediff_env_responder: parameter out of range");
  end

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] op_q, op_d;
  logic [7:0] cond_hi_q, cond_hi_d;
  logic [2:0] cond_lo_q, cond_lo_d;
  logic       key_q;
  logic       start;

  assign start = |(bus.cmd_y & START_MASK);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    cond_hi_d = cond_hi_q;
    cond_lo_d = cond_lo_q;
    if (bus.cond_load) begin
      cond_hi_d = bus.cond_data[11:4];
      cond_lo_d = bus.cond_data[2:0];
    end
    case (state_q)
      IDLE: if (start) begin
        state_d = BUSY;
        cnt_d   = LAT_M1;
      end
      BUSY: if (cnt_q == 8'd0) begin
        state_d = DONE;
        cnt_d   = HOLD_M1;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
      DONE: if (cnt_q == 8'd0) begin
        state_d = IDLE;
        if (op_q != 8'hFF) op_d = op_q + 8'd1;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      op_q      <= 8'd0;
      cond_hi_q <= 8'd0;
      cond_lo_q <= 3'd0;
      key_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      cond_hi_q <= cond_hi_d;
      cond_lo_q <= cond_lo_d;
      key_q     <= 1'b1;
    end
  end

  assign bus.x         = {cond_hi_q, state_q == DONE, cond_lo_q};
  assign bus.keyinput0 = key_q & KEY_VAL;
  assign bus.key_valid = key_q;
  assign bus.busy      = (state_q == BUSY) || (state_q == DONE);
  assign bus.op_count  = op_q;

`ifdef THREEDIFF_ENV_WDOG_EN
  localparam logic [15:0] WDOG_LIM = 16'(WDOG_CYC);

  logic [15:0] wcnt_q, wcnt_d;
  logic        wdog_q, wdog_d;

  // Counter freezes once the flag is raised; only reset clears the flag.
  always_comb begin
    wcnt_d = wcnt_q;
    wdog_d = wdog_q;
    if (start) begin
      wcnt_d = 16'd0;
    end else if (state_q == IDLE && !wdog_q) begin
      if (wcnt_q == WDOG_LIM) wdog_d = 1'b1;
      else                    wcnt_d = wcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q <= 16'd0;
      wdog_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      wdog_q <= wdog_d;
    end
  end

  assign bus.wdog_flag = wdog_q;
`else
  assign bus.wdog_flag = 1'b0;
`endif
endmodule

// File: tb/tb_threediff_env_responder.sv
// Directed bench for threediff_env_responder (DONE_LAT=4, HOLD_CYC=2, WDOG_CYC=16).
module tb_threediff_env_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  threediff_env_if bus ();

  threediff_env_responder #(
    .DONE_LAT(4), .HOLD_CYC(2), .START_MASK(32'h0440_0200), .KEY_VAL(1'b1), .WDOG_CYC(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic saw_x4;
    bus.cmd_y     = 32'h0;
    bus.cond_load = 1'b0;
    bus.cond_data = 12'h0;
    #2;
    // reset state
    check("rst_x",     32'(bus.x), 32'h0);
    check("rst_key",   32'(bus.keyinput0), 32'h0);
    check("rst_kvld",  32'(bus.key_valid), 32'h0);
    check("rst_busy",  32'(bus.busy), 32'h0);
    check("rst_opcnt", 32'(bus.op_count), 32'h0);
    check("rst_wdog",  32'(bus.wdog_flag), 32'h0);

    // first edge after release drives the key
    rst = 1'b1;
    tick();
    check("key_after_rel",  32'(bus.keyinput0), 32'h1);
    check("kvld_after_rel", 32'(bus.key_valid), 32'h1);
    check("x_after_rel",    32'(bus.x), 32'h0);
    check("busy_after_rel", 32'(bus.busy), 32'h0);

    // non-masked command never starts
    bus.cmd_y = 32'h0000_0001;
    repeat (3) tick();
    check("nomask_busy", 32'(bus.busy), 32'h0);
    check("nomask_x4",   32'(bus.x[3]), 32'h0);

    // single-cycle start pulse at edge N
    bus.cmd_y = 32'h0000_0200;
    tick();
    bus.cmd_y = 32'h0;
    check("lat_busy_N", 32'(bus.busy), 32'h1);
    check("lat_x4_N",   32'(bus.x[3]), 32'h0);
    tick(); tick(); tick();
    check("lat_x4_N3",  32'(bus.x[3]), 32'h0);
    tick();
    check("lat_x4_N4",  32'(bus.x[3]), 32'h1);
    tick();
    check("lat_x4_N5",  32'(bus.x[3]), 32'h1);
    check("lat_busy_N5", 32'(bus.busy), 32'h1);
    tick();
    check("lat_x4_N6",  32'(bus.x[3]), 32'h0);
    check("lat_busy_N6", 32'(bus.busy), 32'h0);
    check("lat_opcnt",  32'(bus.op_count), 32'h1);

    // held start repeats with period 7; start in BUSY/DONE and on the DONE->IDLE edge is ignored
    bus.cmd_y = 32'h0040_0000;
    tick();
    check("hold_busy_M", 32'(bus.busy), 32'h1);
    for (int k = 1; k <= 14; k++) begin
      tick();
      check($sformatf("hold_x4_M%0d", k), 32'(bus.x[3]), ((k % 7 == 4) || (k % 7 == 5)) ? 32'h1 : 32'h0);
    end
    check("hold_opcnt", 32'(bus.op_count), 32'h3);
    bus.cmd_y = 32'h0;
    repeat (8) tick();
    check("hold_opcnt_end", 32'(bus.op_count), 32'h4);
    check("hold_busy_end",  32'(bus.busy), 32'h0);

    // condition register load, x4 masked out of the loaded value
    bus.cond_load = 1'b1;
    bus.cond_data = 12'hFFF;
    tick();
    bus.cond_load = 1'b0;
    bus.cond_data = 12'h000;
    check("cond_x_idle", 32'(bus.x), 32'hFF7);
    bus.cmd_y = 32'h0400_0000;
    tick();
    bus.cmd_y = 32'h0;
    repeat (4) tick();
    check("cond_x_done", 32'(bus.x), 32'hFFF);
    repeat (2) tick();
    check("cond_x_after", 32'(bus.x), 32'hFF7);
    check("cond_opcnt",   32'(bus.op_count), 32'h5);
    // load while busy
    bus.cmd_y = 32'h0000_0200;
    tick();
    bus.cmd_y = 32'h0;
    bus.cond_load = 1'b1;
    bus.cond_data = 12'h5A2;
    tick();
    bus.cond_load = 1'b0;
    check("cond_load_busy", 32'(bus.x), 32'h5A2);

    // reset two cycles into an operation (leftover op finishes first)
    repeat (8) tick();
    bus.cmd_y = 32'h0000_0200;
    tick();
    bus.cmd_y = 32'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("midrst_x",     32'(bus.x), 32'h0);
    check("midrst_busy",  32'(bus.busy), 32'h0);
    check("midrst_opcnt", 32'(bus.op_count), 32'h0);
    check("midrst_key",   32'(bus.keyinput0), 32'h0);
    #3;
    rst = 1'b1;
    saw_x4 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.x[3] !== 1'b0 || bus.busy !== 1'b0) saw_x4 = 1'b1;
    end
    check("midrst_no_pulse", 32'(saw_x4), 32'h0);
    check("midrst_key_back", 32'(bus.keyinput0), 32'h1);

    // watchdog
    rst = 1'b0;
    #3;
    rst = 1'b1;
    repeat (10) tick();
    check("wdog_early", 32'(bus.wdog_flag), 32'h0);
    repeat (10) tick();
`ifdef THREEDIFF_ENV_WDOG_EN
    check("wdog_set", 32'(bus.wdog_flag), 32'h1);
    bus.cmd_y = 32'h0000_0200;
    tick();
    bus.cmd_y = 32'h0;
    tick();
    check("wdog_sticky", 32'(bus.wdog_flag), 32'h1);
`else
    check("wdog_off", 32'(bus.wdog_flag), 32'h0);
    bus.cmd_y = 32'h0000_0200;
    tick();
    bus.cmd_y = 32'h0;
    tick();
    check("wdog_off_after", 32'(bus.wdog_flag), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/threediff_env_responder.md
Name: threediff_env_responder

Overview:
- Environment/plant-side counterpart to the locked threediff controller FSM, closing its loop in system simulation and on FPGA benches.
- Consumes the controller's 32 command outputs and drives its 12 condition inputs plus keyinput0.
- Models actuator completion (x4) with a programmable latency. Static sensor conditions are loaded by the test harness. Drives the correct unlock key after reset.

Parameters:
- DONE_LAT, 4, cycles from command detection to x4 assertion; legal range 1..255.
- HOLD_CYC, 2, cycles x4 stays high once asserted; legal range 1..15.
- START_MASK, 32'h0440_0200, command bits that start an operation (y10, y23, y27; bit n-1 = yn).
- KEY_VAL, 1'b1, correct key level driven on keyinput0.
- WDOG_CYC, 1024, watchdog limit (optional feature only).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- cmd_y  in  32  controller outputs y32..y1 (bit 0 = y1).
- cond_load  in  1  load strobe for static condition bits.
- cond_data  in  12  condition value; bit 3 (x4) ignored.
- x  out  12  condition inputs x12..x1 to the controller (bit 0 = x1).
- keyinput0  out  1  key bit to the controller.
- key_valid  out  1  high once keyinput0 carries KEY_VAL.
- busy  out  1  high in BUSY or DONE.
- op_count  out  8  completed operations, saturating.
- wdog_flag  out  1  watchdog expiry (optional feature; tied 0 otherwise).

Behaviour:
- Reset (rst low, asynchronous): all outputs 0; FSM = IDLE; latency counter 0; condition register 0; key stage 0.
- Key: keyinput0 and key_valid go to KEY_VAL and 1 on the first posedge after rst deasserts, then hold until the next reset.
- Conditions: the condition register drives x bits 0-2 and 4-11. On a posedge with cond_load=1 it loads cond_data[11:4] and [2:0]. Load is independent of FSM state.
- x[3] (x4) = 1 only in the DONE state, registered.
- start = |(cmd_y & START_MASK), sampled at posedge.
- IDLE: if start, go to BUSY and load cnt = DONE_LAT-1; otherwise stay.
- BUSY: if cnt == 0, go to DONE and load cnt = HOLD_CYC-1; otherwise decrement. start is ignored; no abort.
- DONE: x4 = 1. If cnt == 0, go to IDLE and increment op_count, saturating at 255; otherwise decrement. start is ignored.
- Latency: start sampled at edge N gives x4 = 1 in the cycles after edges N+DONE_LAT .. N+DONE_LAT+HOLD_CYC-1. x4 is low again after edge N+DONE_LAT+HOLD_CYC.
- Back-to-back: a start present on the same edge that DONE returns to IDLE is not taken. It is taken on the following edge if still asserted.
- busy = 1 in BUSY and DONE.
- Reset mid-operation returns to IDLE immediately; op_count is cleared.
- Undefined FSM encodings go to IDLE.

Optional Feature:
- Macro: THREEDIFF_ENV_WDOG_EN.
- Enabled:
  - A 16-bit counter increments every cycle in IDLE with start=0 and clears on start.
  - When it reaches WDOG_CYC, wdog_flag is set and the counter stops.
  - wdog_flag is sticky until reset.
- Disabled: no counter is built; wdog_flag is constant 0.

Test Plan:
- Reset release: rst low→high, then one posedge → keyinput0=1 and key_valid=1. x, busy, op_count remain 0.
- Latency: DONE_LAT=4, HOLD_CYC=2; pulse cmd_y=32'h0000_0200 for 1 cycle at edge N → x[3]=1 after edges N+4 and N+5, 0 after N+6; op_count=1.
- Ignore during op: hold cmd_y=32'h0040_0000 continuously → x4 pattern repeats every 7 cycles (4 busy + 2 done + 1 idle re-detect). Non-masked cmd_y=32'h0000_0001 never starts.
- Conditions: cond_load=1 with cond_data=12'hFFF → x=12'hFF7 (x4 still 0); then a started op → x=12'hFFF during DONE.
- Reset mid-BUSY: assert rst two cycles after start → x=0, busy=0, op_count=0 immediately. No x4 pulse follows.
- Watchdog (macro defined, WDOG_CYC=16): idle 16 cycles with no start → wdog_flag=1 and stays 1 after a later start. With macro undefined → wdog_flag stays 0.
